// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
// Issues periodic one-cycle conversion requests to the ADC front end, waits for
// each result (with a timeout), buffers it in a one-entry valid/ready stage and
// counts every lost sample (missed tick or full buffer) in a saturating counter.
module adc_sample_scheduler #(
  parameter int NUM_DEVICES    = 2,
  parameter int SAMPLE_WIDTH   = 12,
  parameter int PERIOD_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [PERIOD_WIDTH-1:0]             period_i,
  input  logic                                clear_i,
  output logic                                request_o,
  input  logic [NUM_DEVICES*SAMPLE_WIDTH-1:0] data_i,
  input  logic                                data_valid_i,
  output logic [NUM_DEVICES*SAMPLE_WIDTH-1:0] sample_o,
  output logic                                sample_valid_o,
  input  logic                                sample_ready_i,
  output logic                                overrun_o,
  output logic [7:0]                          overrun_count_o,
  output logic                                timeout_o,
  output logic                                busy_o
);

  // The timeout counter runs 0..TIMEOUT_CYCLES-1; TIMEOUT_CYCLES >= 2 keeps
  // the width at least one bit.
  localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_TICK = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [PERIOD_WIDTH-1:0]   period_cnt_reg, period_cnt_next;
  logic [TIMEOUT_WIDTH-1:0]  timeout_cnt_reg, timeout_cnt_next;
  logic                      request_reg, request_next;
  logic                      timeout_reg, timeout_next;
  logic                      sample_valid_reg, sample_valid_next;
  logic                      overrun_reg, overrun_next;
  logic [7:0]                overrun_count_reg, overrun_count_next;

  logic [PERIOD_WIDTH-1:0]   period_reload;
  logic                      tick;
  logic                      capture;
  logic                      missed_tick;
  logic                      load_sample;
  logic                      drop_sample;
  logic [1:0]                overrun_inc;
  logic [8:0]                overrun_sum;

  // The counter is loaded with interval-1 in the cycle before a request, so it
  // reaches zero in the last cycle of the interval; periods below 2 act as 2.
  assign period_reload = (period_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1)
                                                       : period_i - PERIOD_WIDTH'(1);
  assign tick = (period_cnt_reg == '0);

  // State and control registers; reset discards any conversion in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      period_cnt_reg    <= '0;
      timeout_cnt_reg   <= '0;
      request_reg       <= 1'b0;
      timeout_reg       <= 1'b0;
      sample_valid_reg  <= 1'b0;
      overrun_reg       <= 1'b0;
      overrun_count_reg <= '0;
    end else begin
      state_reg         <= state_next;
      period_cnt_reg    <= period_cnt_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      request_reg       <= request_next;
      timeout_reg       <= timeout_next;
      sample_valid_reg  <= sample_valid_next;
      overrun_reg       <= overrun_next;
      overrun_count_reg <= overrun_count_next;
    end
  end

  // Sequencer: request cadence, data/timeout wait and missed-tick detection.
  always_comb begin
    state_next       = state_reg;
    period_cnt_next  = period_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    request_next     = 1'b0;
    timeout_next     = 1'b0;
    capture          = 1'b0;
    missed_tick      = 1'b0;

    if (!tick) begin
      period_cnt_next = period_cnt_reg - PERIOD_WIDTH'(1);
    end

    case (state_reg)
      IDLE: begin
        if (enable_i) begin
          request_next     = 1'b1;
          state_next       = WAIT_DATA;
          period_cnt_next  = period_reload;
          timeout_cnt_next = '0;
        end
      end

      WAIT_DATA: begin
        // A strobe in the final allowed cycle still wins over the timeout.
        if (data_valid_i) begin
          capture    = 1'b1;
          state_next = WAIT_TICK;
        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          state_next   = WAIT_TICK;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + TIMEOUT_WIDTH'(1);
        end
        // The interval ended before the conversion finished: the tick is lost,
        // not queued, and the cadence carries on from here.
        if (tick) begin
          missed_tick     = 1'b1;
          period_cnt_next = period_reload;
        end
      end

      WAIT_TICK: begin
        if (tick) begin
          if (enable_i) begin
            request_next     = 1'b1;
            state_next       = WAIT_DATA;
            period_cnt_next  = period_reload;
            timeout_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output buffer handshake and overrun accounting.
  always_comb begin
    load_sample        = capture && (!sample_valid_reg || sample_ready_i);
    drop_sample        = capture && !load_sample;
    sample_valid_next  = sample_valid_reg;
    overrun_next       = overrun_reg;
    overrun_count_next = overrun_count_reg;

    if (load_sample) begin
      sample_valid_next = 1'b1;
    end else if (sample_valid_reg && sample_ready_i) begin
      sample_valid_next = 1'b0;
    end

    // A missed tick and a dropped sample can coincide, adding two at once.
    overrun_inc = {1'b0, missed_tick} + {1'b0, drop_sample};
    overrun_sum = {1'b0, overrun_count_reg} + {7'd0, overrun_inc};

    if (clear_i) begin
      overrun_next       = 1'b0;
      overrun_count_next = '0;
    end else if (overrun_inc != 2'd0) begin
      overrun_next       = 1'b1;
      overrun_count_next = overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
    end
  end

  // One holding register per ADC channel; the last sample stays visible after
  // the consumer drains the buffer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEVICES; gi++) begin : g_lane
      logic [SAMPLE_WIDTH-1:0] lane_reg;

      // Load this channel's slice whenever a captured result is accepted.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lane_reg <= '0;
        end else if (load_sample) begin
          lane_reg <= data_i[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
      end

      assign sample_o[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane_reg;
    end
  endgenerate

  assign request_o       = request_reg;
  assign timeout_o       = timeout_reg;
  assign sample_valid_o  = sample_valid_reg;
  assign overrun_o       = overrun_reg;
  assign overrun_count_o = overrun_count_reg;
  assign busy_o          = (state_reg == WAIT_DATA) || (state_reg == WAIT_TICK);

endmodule
